// File: rtl/data_mem_ctrl.sv
// Handshaked byte-lane data memory with programmable access latency.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN: flag and suppress misaligned accesses.
module data_mem_ctrl #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int LAT        = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DM_ADDRESS+1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   state_t state, state_nxt;
   logic [3:0] cnt;

   logic                  we_q;
   logic [2:0]            f3_q;
   logic [DM_ADDRESS+1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;

   logic [DATA_W-1:0] mem [2**DM_ADDRESS];

   logic [DM_ADDRESS-1:0] idx;
   logic [1:0]            off;
   logic                  accept;
   logic                  fire;
   logic                  trap;
   logic [3:0]            be;
   logic [DATA_W-1:0]     wlane;
   logic [DATA_W-1:0]     word;
   logic [DATA_W-1:0]     ld;
   logic [DATA_W-1:0]     rdata_nxt;
   logic [7:0]            b_sel;
   logic [15:0]           h_sel;

   assign idx    = addr_q[DM_ADDRESS+1:2];
   assign off    = addr_q[1:0];
   assign accept = req_valid && req_ready;
   assign fire   = (state == BUSY) && (cnt == 4'd0);
   assign word   = mem[idx];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
   // A halfword needs an even offset, a word needs offset zero
   always_comb begin
      trap = 1'b0;
      case (f3_q)
         3'b001:  trap = off[0];
         3'b101:  trap = off[0] && !we_q;
         3'b010:  trap = (off != 2'b00);
         default: trap = 1'b0;
      endcase
   end
`else
   assign trap = 1'b0;
`endif

   // Lane selection for loads and byte enables for stores
   always_comb begin
      b_sel = word[8*off +: 8];
      h_sel = off[1] ? word[31:16] : word[15:0];
      be    = 4'b0000;
      wlane = '0;
      ld    = word;
      case (f3_q)
         3'b000: begin
            be    = 4'b0001 << off;
            wlane = {4{wdata_q[7:0]}};
            ld    = {{24{b_sel[7]}}, b_sel};
         end
         3'b100: ld = {24'd0, b_sel};
         3'b001: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
            ld    = {{16{h_sel[15]}}, h_sel};
         end
         3'b101: ld = {16'd0, h_sel};
         3'b010: begin
            be    = 4'b1111;
            wlane = wdata_q;
         end
         default: ;
      endcase
      if (!we_q || trap) be = 4'b0000;
      rdata_nxt = (we_q || trap) ? '0 : ld;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latency counter and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 4'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept)
            cnt <= LAT_M1;
         else if (state == BUSY && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (fire) begin
            rsp_rdata <= rdata_nxt;
            rsp_err   <= trap;
         end
      end
   end

   // Request capture at acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Byte-lane write; a reset on the access edge aborts it
   always_ff @(posedge clk) begin
      if (fire && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, handshaked data memory for the RISC-V datapath, replacing the single-cycle combinational-read data memory.
- Adds byte-lane stores (SB/SH modify only the addressed lanes) and byte-offset-aware loads with sign/zero extension.
- Adds a programmable access latency and request/response valid-ready handshakes, so the core can later be pipelined or stalled on memory.
- Sits between the ALU address output and the writeback mux.

Parameters:
- DM_ADDRESS, 9, word-index width; depth = 2**DM_ADDRESS 32-bit words; byte address width = DM_ADDRESS+2.
- DATA_W, 32, data width; fixed at 32, since lane logic assumes 4 byte lanes.
- LAT, 1, clock edges from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load (replaces MemWrite/MemRead).
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  DM_ADDRESS+2  byte address; bits 1:0 are the byte offset.
- req_wdata  in  DATA_W  store data from rs2.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access flag (see Optional Feature).

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (rst=1 at posedge), state forced to IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- Memory contents are not reset. Reset during BUSY aborts the access with no memory write. Reset during RESP drops the response.
- IDLE: req_ready=1. When req_valid&&req_ready at posedge, capture we/funct3/addr/wdata, load counter with LAT-1, go to BUSY.
- BUSY: req_ready=0. Counter decrements each edge. At the edge where counter==0, perform the access, register the result, and go to RESP.
  - rsp_valid therefore rises exactly LAT edges after the acceptance edge.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. When rsp_valid&&rsp_ready at posedge, go to IDLE. No back-to-back overlap: req_ready stays 0 until IDLE.
- Word index = addr[DM_ADDRESS+1:2]; off = addr[1:0].
- Loads:
  - LB/LBU (000/100) select byte lane off.
  - LH/LHU (001/101) select halfword off[1].
  - LW (010) selects the whole word.
  - Sign-extend from bit 7 (LB) or bit 15 (LH); zero-extend for LBU/LHU.
  - Other funct3 values return the full word.
- Stores:
  - SB writes lane off with wdata[7:0].
  - SH writes lanes {off[1],0}/{off[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Lanes not written keep their old value. Other funct3 values perform no write.
- Alignment rules: LH/LHU/SH require off[0]=0; LW/SW require off=00.
  - Without the macro, misaligned accesses use the lane rules above with the low offset bits ignored (halfword at off&2'b10, word at off 00).
- The read and write of one access happen on the same edge. A read returns the pre-write contents only if it were a separate request; a single request is never both a load and a store.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned request still completes the handshake with the same latency, but performs no memory write and returns rsp_rdata=0 with rsp_err=1.
- Undefined: rsp_err is tied to 0, and misaligned accesses follow the masking rule above.

Test Plan:
- Reset, then SW addr 0x010 wdata 0xDEADBEEF, LAT=1 -> rsp_valid rises 1 edge after acceptance. A following LW 0x010 returns 0xDEADBEEF.
- Word 0x010 = 0xDEADBEEF, then SB addr 0x011 wdata 0x12 -> LW returns 0xDEAD12EF. LB 0x011 returns 0x00000012. LB 0x013 returns 0xFFFFFFDE. LBU 0x013 returns 0x000000DE.
- SH addr 0x022 wdata 0x8001 onto a zero word -> LW 0x020 returns 0x80010000. LH 0x022 returns 0xFFFF8001. LHU 0x022 returns 0x00008001.
- LAT=4 build, load issued with rsp_ready held 0 for 3 cycles -> rsp_valid asserts 4 edges after acceptance. rsp_rdata stays stable while stalled, req_ready stays 0 until the rsp handshake, and a new req_valid is ignored until then.
- rst asserted while in BUSY on an SW to 0x040 (old value 0x11111111) -> next edge is IDLE with rsp_valid=0, and a later LW 0x040 returns 0x11111111.
- With DATA_MEM_MISALIGN_TRAP_EN: SW addr 0x041 -> rsp_err=1, rsp_rdata=0, memory unchanged. Without it: same request writes word 0x040 and rsp_err=0.
